regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file with scoreboard, the next generation of the core's register file. It provides RPORTS combinational read ports and two write ports: A for in-order pipeline writeback, B for long-latency writeback such as load or divide. A per-register busy scoreboard tracks outstanding long-latency results. A sequential clear sweep zeroes the file without asserting reset. Sits between decode (reads, scoreboard set) and the writeback stages.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers, 16 or 32. AW = clog2(NREGS).
- RPORTS, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = write-to-read forwarding in the same cycle; 0 = reads come from the array only.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- raddr  in  RPORTS*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rdata  out  RPORTS*XLEN  packed read data.
- rbusy  out  RPORTS  scoreboard busy bit for each read address.
- wa_en, wa_addr, wa_data  in  1/AW/XLEN  write port A.
- wb_en, wb_addr, wb_data  in  1/AW/XLEN  write port B; a B write also clears busy[wb_addr].
- sb_set_en, sb_set_addr  in  1/AW  marks a register busy (long-latency op issued).
- busy_vec  out  NREGS  registered scoreboard state.
- clr_req  in  1  pulse; starts the clear sweep.
- clr_busy  out  1  high while the sweep runs.

## Operation
- Register x0:
  - Reads always return 0.
  - Writes to x0 are discarded.
  - busy[0] is never set.
- Writes commit on the rising edge and are visible from the array on the next cycle.
- Write collision: if wa_en and wb_en target the same address in the same cycle, A's data is written and B's data is dropped. busy[wb_addr] is still cleared.
- Reads with BYPASS=1:
  - If raddr_i matches an enabled write address (non-zero), rdata_i returns that write's data.
  - If both A and B match, A's data is returned.
  - Otherwise rdata_i returns the array value.
- Reads with BYPASS=0: rdata_i always returns the array value.
- rbusy_i:
  - BYPASS=1: busy[raddr_i] AND NOT (wb_en AND wb_addr==raddr_i).
  - BYPASS=0: busy[raddr_i].
  - Always 0 for x0.
- Scoreboard update each cycle:
  - Clear busy[wb_addr] if wb_en.
  - Then set busy[sb_set_addr] if sb_set_en and the address is non-zero.
  - If set and clear hit the same address in the same cycle, set wins.
- Clear sweep FSM, states IDLE and SWEEP, with counter idx of width AW:
  - IDLE: when clr_req=1, go to SWEEP with idx=1.
  - SWEEP: each cycle write 0 to x[idx] and clear busy[idx], then idx++. After idx=NREGS-1 is cleared, return to IDLE.
  - clr_busy is 1 in SWEEP and 0 in IDLE.
  - clr_req is ignored while in SWEEP.
  - During SWEEP, wa_en, wb_en and sb_set_en are ignored: no array writes, no scoreboard changes, no bypass. Reads return current array contents.
- Reset: all registers 0, busy_vec 0, FSM to IDLE, idx 0, clr_busy 0.

## Timing
- Read latency is 0 cycles (combinational from raddr and write ports).
- Write-to-array-read latency is 1 cycle, or 0 cycles via bypass.
- busy_vec reflects a set or clear on the cycle after sb_set_en or wb_en.
- Sweep: clr_req seen at edge N → clr_busy=1 for cycles N+1 .. N+NREGS-1, i.e. NREGS-1 cycles (31 for NREGS=32). clr_busy=0 at N+NREGS. A new clr_req is accepted from that cycle.
- rst during a sweep: the next cycle is IDLE with everything zeroed. rst has priority over every other input.

## Test plan
- Reset, then write x5=0xDEADBEEF via A; next cycle read x5 on both ports → 0xDEADBEEF. Read x0 → 0.
- BYPASS=1: wa x7=0x11 and wb x7=0x22 in the same cycle, reading x7 → rdata=0x11 that cycle and 0x11 the next; busy[7] cleared.
- sb_set x3 → busy_vec[3]=1 next cycle and rbusy=1. wb x3=0x55 → that cycle rbusy=0 and rdata=0x55 (BYPASS=1); busy_vec[3]=0 next cycle. Same-cycle sb_set x3 + wb x3 → busy remains 1.
- Fill x1..x31 with index values, pulse clr_req → clr_busy high exactly 31 cycles. Writes issued during the sweep are dropped. All reads return 0 afterwards, busy_vec=0.
- Assert rst at sweep cycle 10 → next cycle clr_busy=0, all registers 0, busy_vec=0. A following clr_req starts a full 31-cycle sweep.
- NREGS=16, RPORTS=3, BYPASS=0: write x15=0xA5A5A5A5, reading x15 in the same cycle → old value (0). Next cycle all three ports → 0xA5A5A5A5.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- integer register file with a long-latency busy scoreboard.
//
// Sits between decode (register reads, scoreboard set on issue of a
// long-latency op) and the writeback stages (port A: in-order pipeline
// writeback, port B: load/divide style writeback that also retires the
// scoreboard entry). A clear sweep zeroes the file one register per cycle
// without asserting reset.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   raddr  [RPORTS*AW]       packed read addresses, port i at [i*AW +: AW]
//   rdata  [RPORTS*XLEN]     packed read data (combinational)
//   rbusy  [RPORTS]          scoreboard busy bit seen by each read port
//   wa_en/wa_addr/wa_data    write port A (wins over B on collision)
//   wb_en/wb_addr/wb_data    write port B, also clears busy[wb_addr]
//   sb_set_en/sb_set_addr    marks a register busy
//   busy_vec [NREGS]         registered scoreboard state
//   clr_req                  pulse, starts the clear sweep
//   clr_busy                 high while the sweep runs
// -----------------------------------------------------------------------------
module regfile_sb #(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int RPORTS = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RPORTS*AW-1:0]   raddr,
   output logic [RPORTS*XLEN-1:0] rdata,
   output logic [RPORTS-1:0]      rbusy,
   input  logic                   wa_en,
   input  logic [AW-1:0]          wa_addr,
   input  logic [XLEN-1:0]        wa_data,
   input  logic                   wb_en,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   sb_set_en,
   input  logic [AW-1:0]          sb_set_addr,
   output logic [NREGS-1:0]       busy_vec,
   input  logic                   clr_req,
   output logic                   clr_busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            sweep_act;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;

   // Write-side activity after the sweep gate. *_act qualifies the enable
   // only; *_hit additionally excludes x0 so it never writes or forwards.
   logic wa_act, wb_act, sb_act;
   logic wa_hit, wb_hit;

   // --------------------------------------------------------------------------
   // Clear sweep FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // --------------------------------------------------------------------------
   // Clear sweep FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_SWEEP;
               idx_d   = AW'(1);   // x0 is hard-wired zero, start at x1
            end
         end
         ST_SWEEP: begin
            // clr_req is deliberately not looked at here
            if (idx_q == AW'(NREGS - 1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Clear sweep FSM: outputs
   // --------------------------------------------------------------------------
   always_comb begin
      sweep_act = (state_q == ST_SWEEP);
      clr_busy  = sweep_act;
   end

   // While sweeping, every write-side request is dropped outright so the
   // sweep has exclusive ownership of the array and scoreboard.
   always_comb begin
      wa_act = wa_en     & ~sweep_act;
      wb_act = wb_en     & ~sweep_act;
      sb_act = sb_set_en & ~sweep_act;
      wa_hit = wa_act & (wa_addr != '0);
      wb_hit = wb_act & (wb_addr != '0);
   end

   // --------------------------------------------------------------------------
   // Array and scoreboard next-state
   // --------------------------------------------------------------------------
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (sweep_act) begin
         regs_d[idx_q] = '0;
         busy_d[idx_q] = 1'b0;
      end else begin
         // B first so that A overwrites it on an address collision
         if (wb_hit) regs_d[wb_addr] = wb_data;
         if (wa_hit) regs_d[wa_addr] = wa_data;
         // Clear before set: an issue and a retire to the same register in
         // the same cycle leaves it busy (the new op is still outstanding).
         if (wb_act) busy_d[wb_addr] = 1'b0;
         if (sb_act && (sb_set_addr != '0)) busy_d[sb_set_addr] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   // --------------------------------------------------------------------------
   // Array and scoreboard state
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   // --------------------------------------------------------------------------
   // Read ports
   // --------------------------------------------------------------------------
   for (genvar p = 0; p < RPORTS; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            rb;

      always_comb begin
         ra = raddr[p*AW +: AW];
         rd = regs_q[ra];
         rb = busy_q[ra];
         if (BYPASS != 0) begin
            if (wa_hit && (wa_addr == ra)) begin
               rd = wa_data;
            end else if (wb_hit && (wb_addr == ra)) begin
               rd = wb_data;
            end
            // The retiring result is being forwarded, so the reader must
            // not stall on it.
            if (wb_act && (wb_addr == ra)) begin
               rb = 1'b0;
            end
         end
         if (ra == '0) begin
            rd = '0;
            rb = 1'b0;
         end
      end

      assign rdata[p*XLEN +: XLEN] = rd;
      assign rbusy[p]              = rb;
   end

endmodule
